vol_bar_render: RTL

VOL_BAR_RENDER -- requirements
Module: vol_bar_render

---
 rtl/vol_bar_render.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vol_bar_render.sv
// Volume bar renderer for a WIDTH x HEIGHT RGB565 OLED.
// Two-stage pixel pipeline (coordinates, then colour) driven by the OLED
// driver's sample requests, with per-frame shadowing of all render inputs
// and a peak-hold marker that decays one level per frame after a hold time.
module vol_bar_render #(
   parameter int WIDTH            = 96,
   parameter int HEIGHT           = 64,
   parameter int PEAK_HOLD_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_begin,
   input  logic        sample_pixel,
   input  logic [12:0] pixel_index,
   input  logic [3:0]  vol_level,
   input  logic        border_en,
   input  logic        bar_en,
   input  logic [15:0] bor_col,
   input  logic [15:0] bg_col,
   input  logic [15:0] volCol_top,
   input  logic [15:0] volCol_mid,
   input  logic [15:0] volCol_bot,
   output logic [15:0] oled_data,
   output logic [3:0]  peak_level
);

   localparam int NPIX   = WIDTH * HEIGHT;
   localparam int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int HW_RAW = $clog2(PEAK_HOLD_FRAMES + 1);
   localparam int HW     = (HW_RAW > 0) ? HW_RAW : 1;

   // Bar geometry in screen coordinates.
   localparam int BAR_X0   = 40;
   localparam int BAR_X1   = 55;
   localparam int BAR_YBOT = 58;
   localparam int NSEG     = 15;

   // Per-frame shadow copies of everything the renderer looks at.
   logic [3:0]  sh_vol;
   logic        sh_border_en;
   logic        sh_bar_en;
   logic [15:0] sh_bor;
   logic [15:0] sh_bg;
   logic [15:0] sh_top;
   logic [15:0] sh_mid;
   logic [15:0] sh_bot;

   // Stage-1 pipeline registers.
   logic          s1_valid;
   logic          s1_oor;
   logic [XW-1:0] s1_x;
   logic [YW-1:0] s1_y;

   logic [HW-1:0] hold_cnt;
   logic [15:0]   pix_colour;

   // Capture render inputs at the start of each frame.
   // NOTE: reset is sampled on the clock edge and every register uses <=, so
   // all state moves together on the edge with no ordering races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_vol       <= '0;
         sh_border_en <= 1'b0;
         sh_bar_en    <= 1'b0;
         sh_bor       <= '0;
         sh_bg        <= '0;
         sh_top       <= '0;
         sh_mid       <= '0;
         sh_bot       <= '0;
      end else if (frame_begin) begin
         sh_vol       <= vol_level;
         sh_border_en <= border_en;
         sh_bar_en    <= bar_en;
         sh_bor       <= bor_col;
         sh_bg        <= bg_col;
         sh_top       <= volCol_top;
         sh_mid       <= volCol_mid;
         sh_bot       <= volCol_bot;
      end
   end

   // Peak hold: jump up immediately, hold for a while, then fall one level per frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         peak_level <= '0;
         hold_cnt   <= '0;
      end else if (frame_begin) begin
         if (vol_level > peak_level) begin
            peak_level <= vol_level;
            hold_cnt   <= HW'(PEAK_HOLD_FRAMES);
         end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
         end else if (peak_level != '0) begin
            peak_level <= peak_level - 1'b1;
         end
      end
   end

   // Stage 1: split the linear index into x/y and flag off-screen addresses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_oor   <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
      end else begin
         s1_valid <= sample_pixel;
         if (sample_pixel) begin
            s1_oor <= (int'({19'd0, pixel_index}) >= NPIX);
            s1_x   <= XW'(int'({19'd0, pixel_index}) % WIDTH);
            s1_y   <= YW'(int'({19'd0, pixel_index}) / WIDTH);
         end
      end
   end

   int x_i;
   int y_i;
   int d_i;
   int seg;
   logic in_seg;
   logic is_border;

   // Colour of the stage-1 pixel from the shadowed theme, border over bar over background.
   // NOTE: every variable gets a default at the top so no path leaves a latch.
   always_comb begin
      x_i        = int'(s1_x);
      y_i        = int'(s1_y);
      d_i        = BAR_YBOT - y_i;
      seg        = d_i / 3;
      in_seg     = (x_i >= BAR_X0) && (x_i <= BAR_X1) && (d_i >= 0)
                   && (d_i < 3 * NSEG) && ((d_i % 3) != 2);
      is_border  = (x_i == 0) || (x_i == WIDTH - 1) || (y_i == 0) || (y_i == HEIGHT - 1);
      pix_colour = sh_bg;
      if (!s1_oor) begin
         if (sh_bar_en && in_seg) begin
            if ((peak_level != '0) && (seg == int'(peak_level) - 1)) begin
               pix_colour = sh_top;
            end else if (seg < int'(sh_vol)) begin
               if (seg < 5)       pix_colour = sh_bot;
               else if (seg < 10) pix_colour = sh_mid;
               else               pix_colour = sh_top;
            end
         end
         if (sh_border_en && is_border) begin
            pix_colour = sh_bor;
         end
      end
   end

   // Stage 2: publish the colour; hold the last value when no pixel is in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         oled_data <= '0;
      end else if (s1_valid) begin
         oled_data <= pix_colour;
      end
   end

endmodule
